// File: rtl/dispensador_troco_pkg.sv
// dispensador_troco_pkg: state encoding, coin values and default price shared by the change dispenser.
package dispensador_troco_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        OFFER  = 2'd2,
        DONE   = 2'd3
    } estado_t;

    localparam logic [4:0] MOEDA_5  = 5'd5;
    localparam logic [4:0] MOEDA_10 = 5'd10;
    localparam logic [4:0] MOEDA_20 = 5'd20;

    localparam int PRICE_DEFAULT = 40;

endpackage

// File: rtl/dispensador_troco_seletor_moeda.sv
// seletor_moeda: picks the largest available coin that fits the remainder; flags when none fits.
module seletor_moeda
    import dispensador_troco_pkg::*;
#(
    parameter int SALDO_W = 6,
    parameter int COIN_W  = 5
) (
    input  logic [SALDO_W-1:0] resto,
    input  logic               tem_20,
    input  logic               tem_10,
    input  logic               tem_5,
    output logic [COIN_W-1:0]  moeda,
    output logic               nenhuma
);

    logic cabe_20, cabe_10, cabe_5;

    always_comb begin
        cabe_20 = tem_20 && (32'(resto) >= 32'(MOEDA_20));
        cabe_10 = tem_10 && (32'(resto) >= 32'(MOEDA_10));
        cabe_5  = tem_5  && (32'(resto) >= 32'(MOEDA_5));
        moeda   = cabe_20 ? COIN_W'(MOEDA_20) :
                  cabe_10 ? COIN_W'(MOEDA_10) :
                  cabe_5  ? COIN_W'(MOEDA_5)  : '0;
        nenhuma = !(cabe_20 || cabe_10 || cabe_5);
    end

endmodule

// File: rtl/dispensador_troco.sv
// dispensador_troco: pays sale change as 20/10/5 coins over a valid/ack handshake.
// Optional finite coin stock enabled by defining TROCO_ESTOQUE_EN.
module dispensador_troco
    import dispensador_troco_pkg::*;
#(
    parameter int PRICE   = PRICE_DEFAULT,
    parameter int SALDO_W = 6,
    parameter int COIN_W  = 5
`ifdef TROCO_ESTOQUE_EN
    ,
    parameter int STOCK_INIT = 4
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vendeu,
    input  logic [SALDO_W-1:0] saldo,
    output logic               ready,
    output logic [COIN_W-1:0]  moeda_troco,
    output logic               troco_valid,
    input  logic               troco_ack,
    output logic               done,
    output logic               erro
);

    estado_t            estado, prox;
    logic [SALDO_W-1:0] resto;
    logic [COIN_W-1:0]  moeda_sel;
    logic               nenhuma, err_r, aceita;
    logic               tem_20, tem_10, tem_5;

`ifdef TROCO_ESTOQUE_EN
    logic [3:0] est_20, est_10, est_5;

    always_ff @(posedge clk) begin
        if (reset) begin
            est_20 <= 4'(STOCK_INIT);
            est_10 <= 4'(STOCK_INIT);
            est_5  <= 4'(STOCK_INIT);
        end else if (estado == OFFER && troco_ack) begin
            est_20 <= est_20 - 4'(moeda_troco == COIN_W'(MOEDA_20));
            est_10 <= est_10 - 4'(moeda_troco == COIN_W'(MOEDA_10));
            est_5  <= est_5  - 4'(moeda_troco == COIN_W'(MOEDA_5));
        end
    end

    assign tem_20 = est_20 != 4'd0;
    assign tem_10 = est_10 != 4'd0;
    assign tem_5  = est_5  != 4'd0;
`else
    assign tem_20 = 1'b1;
    assign tem_10 = 1'b1;
    assign tem_5  = 1'b1;
`endif

    seletor_moeda #(.SALDO_W(SALDO_W), .COIN_W(COIN_W)) u_seletor (
        .resto   (resto),
        .tem_20  (tem_20),
        .tem_10  (tem_10),
        .tem_5   (tem_5),
        .moeda   (moeda_sel),
        .nenhuma (nenhuma)
    );

    assign aceita      = 32'(saldo) >= PRICE;
    assign ready       = estado == IDLE;
    assign troco_valid = estado == OFFER;
    assign done        = estado == DONE;
    assign erro        = done && err_r;

    always_comb begin
        prox = estado;
        case (estado)
            IDLE:    prox = vendeu ? (aceita ? SELECT : DONE) : IDLE;
            SELECT:  prox = (resto == '0 || nenhuma) ? DONE : OFFER;
            OFFER:   prox = troco_ack ? SELECT : OFFER;
            default: prox = IDLE;
        endcase
    end

    // A zero remainder also reports nenhuma, so it is tested first to avoid a false error.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado      <= IDLE;
            resto       <= '0;
            moeda_troco <= '0;
            err_r       <= 1'b0;
        end else begin
            estado <= prox;
            case (estado)
                IDLE: if (vendeu) begin
                    resto <= aceita ? saldo - SALDO_W'(PRICE) : '0;
                    err_r <= !aceita;
                end
                SELECT: if (resto != '0) begin
                    if (nenhuma) err_r <= 1'b1;
                    else moeda_troco <= moeda_sel;
                end
                OFFER: if (troco_ack) begin
                    resto       <= resto - SALDO_W'(moeda_troco);
                    moeda_troco <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
